// File: rtl/run_detect_scheduler.sv
// Shares one run-of-ones Mealy detector across NUM_CH serial bit channels. Each
// channel keeps its own saturating run counter, and one round-robin slot is granted per cycle.
// Latency: det_* is registered one cycle after the transfer edge. Throughput is one transfer per cycle.
// Backpressure: req_ready is a one-hot grant. A channel that is not granted keeps its bit pending.
// Optional feature: define RUN_DETECT_SCHED_HIT_EN to add the per-channel hit_sticky output.

module run_detect_scheduler #(
    parameter  int NUM_CH  = 4,
    parameter  int RUN_LEN = 4,
    localparam int CW      = $clog2(NUM_CH),
    localparam int KW      = $clog2(RUN_LEN + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req_valid,
    input  logic [NUM_CH-1:0] req_bit,
    output logic [NUM_CH-1:0] req_ready,
    input  logic [NUM_CH-1:0] ch_clear,
    output logic              det_valid,
    output logic [CW-1:0]     det_ch,
    output logic              det_y,
    output logic [KW-1:0]     det_count
`ifdef RUN_DETECT_SCHED_HIT_EN
    ,
    output logic [NUM_CH-1:0] hit_sticky
`endif
);

    // Saturated run state, and the threshold the pre-update context must reach for y=1.
    localparam logic [KW-1:0] CTX_SAT = KW'(RUN_LEN);
    localparam logic [KW-1:0] CTX_HIT = KW'(RUN_LEN - 1);

    // Per-channel saved detector context.
    logic [KW-1:0] ctx_q [NUM_CH];
    logic [KW-1:0] ctx_d [NUM_CH];

    // Round-robin pointer. It holds the channel granted most recently.
    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;

    // Registered result of the shared detector slot.
    logic          det_valid_q, det_valid_d;
    logic [CW-1:0] det_ch_q,    det_ch_d;
    logic          det_y_q,     det_y_d;
    logic [KW-1:0] det_count_q, det_count_d;

    // Grant decision and the shared detector datapath.
    logic          grant_vld;
    logic [CW-1:0] grant_idx;
    logic          grant_bit;
    logic [KW-1:0] base_ctx;
    logic          grant_y;
    logic [KW-1:0] upd_ctx;

    // Channel that sits k places after p in round-robin order. k is in 1..NUM_CH,
    // so a single subtraction brings the sum back into range.
    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end
        return CW'(s);
    endfunction

    // Round-robin search starting just after ptr. No grant is issued while reset is held.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!grant_vld && req_valid[rr_idx(ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = rr_idx(ptr_q, k);
            end
        end
        if (reset) begin
            grant_vld = 1'b0;
            grant_idx = '0;
        end
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Shared Mealy detector. A clear that coincides with the transfer makes the
    // bit be evaluated against an empty context.
    always_comb begin
        grant_bit = req_bit[grant_idx];
        base_ctx  = ch_clear[grant_idx] ? '0 : ctx_q[grant_idx];
        grant_y   = grant_bit && (base_ctx >= CTX_HIT);
        if (!grant_bit) begin
            upd_ctx = '0;
        end else if (base_ctx == CTX_SAT) begin
            upd_ctx = CTX_SAT;
        end else begin
            upd_ctx = base_ctx + KW'(1);
        end
    end

    // Next-state computation. Clears touch only their own channel, and the granted
    // channel takes the detector update.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ctx_d[i] = ch_clear[i] ? '0 : ctx_q[i];
        end
        if (grant_vld) begin
            ctx_d[grant_idx] = upd_ctx;
        end
        ptr_d       = grant_vld ? grant_idx : ptr_q;
        det_valid_d = grant_vld;
        det_ch_d    = grant_vld ? grant_idx : det_ch_q;
        det_y_d     = grant_vld && grant_y;
        det_count_d = grant_vld ? upd_ctx : '0;
    end

    // State registers. Reset gives channel 0 first priority and drops any transfer in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= '0;
            end
            ptr_q       <= CW'(NUM_CH - 1);
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            det_y_q     <= 1'b0;
            det_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
            ptr_q       <= ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
            det_y_q     <= det_y_d;
            det_count_q <= det_count_d;
        end
    end

    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;
    assign det_y     = det_y_q;
    assign det_count = det_count_q;

`ifdef RUN_DETECT_SCHED_HIT_EN
    logic [NUM_CH-1:0] hit_sticky_q;
    logic [NUM_CH-1:0] hit_sticky_d;

    // Sticky hit per channel. A y=1 transfer sets it and wins over a same-cycle clear.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_vld && grant_y && (grant_idx == CW'(i))) begin
                hit_sticky_d[i] = 1'b1;
            end else if (ch_clear[i]) begin
                hit_sticky_d[i] = 1'b0;
            end else begin
                hit_sticky_d[i] = hit_sticky_q[i];
            end
        end
    end

    // Sticky hit register. It loads on the same edge as det_*.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_sticky_q <= '0;
        end else begin
            hit_sticky_q <= hit_sticky_d;
        end
    end

    assign hit_sticky = hit_sticky_q;
`endif

endmodule

// File: tb/tb_run_detect_scheduler.sv
// Directed bench for run_detect_scheduler that checks the DUT against a run-length model on every cycle.
// Latency: results are expected one cycle after each transfer edge.
// Backpressure: the model predicts the one-hot grant, and that prediction is checked before every edge.

module tb_run_detect_scheduler;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int CW = 2;
    localparam int KW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_bit;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  ch_clear;
    logic          det_valid;
    logic [CW-1:0] det_ch;
    logic          det_y;
    logic [KW-1:0] det_count;
`ifdef RUN_DETECT_SCHED_HIT_EN
    logic [N-1:0]  hit_sticky;
`endif

    run_detect_scheduler #(.NUM_CH(N), .RUN_LEN(L)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_bit   (req_bit),
        .req_ready (req_ready),
        .ch_clear  (ch_clear),
        .det_valid (det_valid),
        .det_ch    (det_ch),
        .det_y     (det_y),
        .det_count (det_count)
`ifdef RUN_DETECT_SCHED_HIT_EN
        ,
        .hit_sticky(hit_sticky)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model state. run[i] is the uncapped length of the current run of 1s on
    // channel i, and last is the most recently granted channel.
    int       run [N];
    int       last;
    logic [N-1:0] m_hit;
    int       e_valid, e_ch, e_y, e_count;
    logic [N-1:0] last_rdy;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive the inputs, check the predicted grant, advance the model across the edge, then check the results.
    task automatic step(input logic rst, input logic [N-1:0] v, input logic [N-1:0] b,
                        input logic [N-1:0] c);
        int g;
        int r;
        int y;
        logic [N-1:0] exp_rdy;
        @(negedge clock);
        reset     = rst;
        req_valid = v;
        req_bit   = b;
        ch_clear  = c;
        #1;
        g = -1;
        if (!rst) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && v[(last + k) % N]) g = (last + k) % N;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        last_rdy = req_ready;
        chk("req_ready", int'(req_ready), int'(exp_rdy));

        if (rst) begin
            for (int i = 0; i < N; i++) run[i] = 0;
            last = N - 1; m_hit = '0;
            e_valid = 0; e_ch = 0; e_y = 0; e_count = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i != g && c[i]) begin
                    run[i] = 0;
                    m_hit[i] = 1'b0;
                end
            end
            if (g >= 0) begin
                r = c[g] ? 0 : run[g];
                y = (b[g] && (r + 1 >= L)) ? 1 : 0;
                run[g] = b[g] ? r + 1 : 0;
                if (y == 1) m_hit[g] = 1'b1;
                else if (c[g]) m_hit[g] = 1'b0;
                last = g;
                e_valid = 1; e_ch = g; e_y = y;
                e_count = (run[g] < L) ? run[g] : L;
            end else begin
                e_valid = 0; e_y = 0; e_count = 0;
            end
        end

        @(posedge clock);
        #1;
        chk("det_valid", int'(det_valid), e_valid);
        chk("det_ch",    int'(det_ch),    e_ch);
        chk("det_y",     int'(det_y),     e_y);
        chk("det_count", int'(det_count), e_count);
`ifdef RUN_DETECT_SCHED_HIT_EN
        chk("hit_sticky", int'(hit_sticky), int'(m_hit));
`endif
    endtask

    int ty [6] = '{0, 0, 0, 1, 1, 0};
    int tc [6] = '{1, 2, 3, 4, 4, 0};
    logic [N-1:0] bits1;
    logic [N-1:0] rv, rb, rc;

    initial begin
        reset = 1'b1; req_valid = '0; req_bit = '0; ch_clear = '0;
        for (int i = 0; i < N; i++) run[i] = 0;
        last = N - 1; m_hit = '0;
        e_valid = 0; e_ch = 0; e_y = 0; e_count = 0;

        // Reset state.
        step(1'b1, 4'b0000, 4'b0000, 4'b0000);
        chk("reset_det_valid", int'(det_valid), 0);
        chk("reset_det_count", int'(det_count), 0);

        // Single channel run with saturation: ch0 sends 1,1,1,1,1,0.
        bits1 = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b0001, (i < 5) ? bits1 : 4'b0000, 4'b0000);
            chk("t1_y", int'(det_y), ty[i]);
            chk("t1_count", int'(det_count), tc[i]);
            chk("t1_ch", int'(det_ch), 0);
        end

        // Round-robin fairness with all channels requesting from reset.
        step(1'b1, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b1111, 4'b0000, 4'b0000);
            chk("t2_rdy", int'(last_rdy), 1 << (i % 4));
            chk("t2_ch", int'(det_ch), i % 4);
        end

        // Context isolation between ch1 and ch2.
        step(1'b1, 4'b0000, 4'b0000, 4'b0000);
        step(1'b0, 4'b0110, 4'b0110, 4'b0000);   // ch1 <- 1
        step(1'b0, 4'b0110, 4'b0110, 4'b0000);   // ch2 <- 1
        step(1'b0, 4'b0110, 4'b0010, 4'b0000);   // ch1 <- 1
        step(1'b0, 4'b0110, 4'b0010, 4'b0000);   // ch2 <- 0
        step(1'b0, 4'b0010, 4'b0010, 4'b0000);   // ch1 <- 1 (ctx 3)
        step(1'b0, 4'b0010, 4'b0010, 4'b0000);   // ch1 <- 1
        chk("t3_ch1_y", int'(det_y), 1);
        chk("t3_ch1_count", int'(det_count), 4);
        step(1'b0, 4'b0100, 4'b0100, 4'b0000);   // ch2 <- 1 from ctx 0
        chk("t3_ch2_count", int'(det_count), 1);

        // A clear that collides with a transfer on ch3.
        step(1'b1, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1000, 4'b1000, 4'b0000);
        step(1'b0, 4'b1000, 4'b1000, 4'b1000);
        chk("t4_y", int'(det_y), 0);
        chk("t4_count", int'(det_count), 1);
        step(1'b0, 4'b1000, 4'b1000, 4'b0000);
        chk("t4_count2", int'(det_count), 2);
        step(1'b0, 4'b1000, 4'b1000, 4'b0000);
        chk("t4_count3", int'(det_count), 3);
        chk("t4_y3", int'(det_y), 0);

        // Reset in the middle of a run on ch0.
        step(1'b1, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, 4'b0001, 4'b0000);
        step(1'b1, 4'b0001, 4'b0001, 4'b0000);
        chk("t5_valid_rst", int'(det_valid), 0);
        step(1'b0, 4'b0001, 4'b0001, 4'b0000);
        chk("t5_y", int'(det_y), 0);
        chk("t5_count", int'(det_count), 1);

        // Pointer behaviour and idle cycles.
        step(1'b1, 4'b0000, 4'b0000, 4'b0000);
        step(1'b0, 4'b0100, 4'b0100, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000);
        chk("t6_idle_valid", int'(det_valid), 0);
        chk("t6_idle_ch", int'(det_ch), 2);
        step(1'b0, 4'b1010, 4'b1010, 4'b0000);
        chk("t6_first", int'(det_ch), 3);
        step(1'b0, 4'b1010, 4'b1010, 4'b0000);
        chk("t6_second", int'(det_ch), 1);

        // Mixed traffic with clears and occasional resets, checked against the model only.
        for (int i = 0; i < 60; i++) begin
            rv = N'($urandom_range(0, 15));
            rb = N'($urandom_range(0, 15)) | N'($urandom_range(0, 15));
            rc = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : 4'b0000;
            step(($urandom_range(0, 40) == 0), rv, rb, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
